rmt_ctrl_pkt_tx: RTL and testbench
==================================

Name: rmt_ctrl_pkt_tx

Overview:
- Transmit-side control-packet generator for the RMT pipeline: formats one table/state write command into a VLAN-tagged IPv4/UDP control packet on a 512-bit AXI-Stream master.
- Builds the packet type the pipeline parser consumes: VLAN ID 15, UDP dst port 0xF1F2.
- Sits between the host/config agent and the pipeline's s_axis input, in synthesizable form.
- Computes lengths and the IPv4 header checksum, and honours tready backpressure.

Parameters:
- C_M_AXIS_DATA_WIDTH, 512, master stream width (only 512 supported).
- C_M_AXIS_TUSER_WIDTH, 128, tuser width (driven all zero).
- MAX_PAYLOAD_BYTES, 128, maximum command payload (needs 3 beats).
- SRC_IP, 32'h6f6f6f6f, IPv4 source address.
- DST_IP, 32'hdededede, IPv4 destination address.
- UDP_SPORT, 16'h04d2, UDP source port.
- UDP_DPORT, 16'hf1f2, UDP destination port.
- VLAN_ID, 12'h00f, VLAN ID carried in the 802.1Q tag.

Ports:
- clk  in  1  stream clock
- aresetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_mod_id  in  8  target pipeline module ID (control byte 46)
- cmd_res_id  in  8  target resource/table ID (control byte 47)
- cmd_len  in  8  payload byte count, legal range 1..128
- cmd_payload  in  1024  payload; payload byte k at [8k+7:8k]
- m_axis_tdata  out  512  packet data; byte i at [8i+7:8i]
- m_axis_tkeep  out  64  byte enables
- m_axis_tuser  out  128  all zero
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last beat of packet
- err_len  out  1  one-cycle pulse when an illegal length is dropped

Behaviour:
- Reset (async assert, sync release): state IDLE; cmd_ready=1; m_axis_tvalid=0, tlast=0, tkeep=0, tdata=0; err_len=0; ip_id=16'h0001.
- Byte order: multi-byte header fields are network order, i.e. MSB at the lower byte index.
- Header layout, bytes 0..47:
  - dst MAC 06:07:08:09:0a:0b; src MAC 00:01:02:03:04:05.
  - TPID 0x8100; TCI {4'h0, VLAN_ID}; ethertype 0x0800.
  - IPv4: 0x45, 0x00, total_len, ip_id, flags/frag 0x0000, TTL 0x40, proto 0x11, hdr_csum, SRC_IP, DST_IP.
  - UDP: UDP_SPORT, UDP_DPORT, udp_len, checksum 0x0000.
  - Control bytes: byte 46 = cmd_mod_id, byte 47 = cmd_res_id.
  - Payload byte k is placed at packet byte 48+k.
- Length arithmetic (16-bit): total_len = 30 + cmd_len; udp_len = 10 + cmd_len; packet bytes P = 48 + cmd_len.
- Beat count: 1 if P ≤ 64; 2 if P ≤ 128; else 3.
- Last-beat tkeep: low (P - 64·(beats-1)) bits set; all earlier beats have tkeep all-ones.
- hdr_csum: ones' complement of the 16-bit ones'-complement sum of the ten IPv4 header words, with the checksum word taken as 0. Carries are folded twice.
- FSM states:
  - IDLE: cmd_ready=1. On handshake, latch all command fields, deassert cmd_ready, go to CALC.
    - If cmd_len==0 or cmd_len>128: pulse err_len for one cycle, stay IDLE, emit nothing, ip_id unchanged.
  - CALC (1 cycle): compute lengths and checksum; load beat 0 into the output register; tvalid=1; go to SEND.
  - SEND: beat index b advances only on tvalid && tready.
    - Output is held stable while tready=0.
    - Each advance loads the next beat into the register the same cycle; there is no bubble between beats.
    - On the handshake of the tlast beat: tvalid=0, ip_id += 1 (wraps 0xFFFF→0x0000), cmd_ready=1, go to IDLE.
- Latency: cmd handshake at cycle N → beat 0 valid at N+2; back-to-back packets have a 1-cycle gap minimum (the CALC cycle).
- Command inputs are don't-care after the handshake; only the latched copies are used.
- Reset mid-packet: output drops immediately (tvalid=0); the partial packet is abandoned; ip_id returns to 1.
- tready is allowed to toggle every cycle; no beat is duplicated or skipped.

Decomposition:
- Package rmt_ctrl_pkg holds:
  - header byte offsets (IP at 18, UDP at 38, control at 46, payload at 48);
  - fixed MAC/ethertype/TPID constants;
  - FSM state enum {IDLE, CALC, SEND};
  - function ipv4_csum(header words) returning 16 bits.
- One sub-module, rmt_ctrl_beat_mux: combinationally selects beat b's tdata/tkeep/tlast from the latched header + payload.

Test Plan:
- Basic single beat: reset, cmd_len=16, mod 0x01, res 0x00, payload bytes 0..15 = 0x00..0x0f. Required response:
  - one beat, tkeep=64'hffffffffffffffff, tlast=1;
  - total_len=0x002e, ip_id=0x0001, hdr_csum=0xde22, udp_len=0x001a.
- Two beats: cmd_len=17 → beat0 keep all-ones, beat1 keep=64'h1 with tlast; total_len=0x002f, ip_id=0x0002.
- Max length: cmd_len=128 → 3 beats, last keep=64'h0000ffffffffffff; payload byte 127 lands at beat2 byte 47.
- Backpressure: tready pattern 1,0,0,1,0,1 during a 3-beat packet → each beat is presented unchanged until accepted; exactly 3 handshakes; tlast only on the third.
- Illegal lengths: cmd_len=0, then 129 → err_len pulses twice, no tvalid, ip_id unchanged. A subsequent legal cmd still emits.
- Reset mid-packet: assert aresetn low during beat1 → tvalid=0 immediately. Next packet after release has ip_id=0x0001.

Source files
------------

// File: rtl/rmt_ctrl_pkg.sv
// Shared constants, FSM encoding and checksum helper for the
// RMT control-packet transmitter.
package rmt_ctrl_pkg;

    localparam int ETH_BYTES = 18;
    localparam int IP_OFF    = 18;
    localparam int UDP_OFF   = 38;
    localparam int CTL_OFF   = 46;
    localparam int PAY_OFF   = 48;
    localparam int HDR_BITS  = PAY_OFF * 8;
    localparam int PAY_BITS  = 1024;

    localparam logic [47:0] DST_MAC    = 48'h060708090a0b;
    localparam logic [47:0] SRC_MAC    = 48'h000102030405;
    localparam logic [15:0] TPID       = 16'h8100;
    localparam logic [15:0] ETYPE_IPV4 = 16'h0800;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SEND
    } tx_state_e;

    // Ten header words in any order; carries folded twice.
    function automatic logic [15:0] ipv4_csum(input logic [159:0] w);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < 10; k++) s = s + {16'h0, w[16*k +: 16]};
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        return ~s[15:0];
    endfunction

endpackage

// File: rtl/rmt_ctrl_pkt_tx_if.sv
// Command request and AXI-Stream master bundle for the
// control-packet transmitter.
interface rmt_ctrl_pkt_tx_if;
    import rmt_ctrl_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [7:0]          cmd_mod_id;
    logic [7:0]          cmd_res_id;
    logic [7:0]          cmd_len;
    logic [PAY_BITS-1:0] cmd_payload;
    logic [511:0]        m_axis_tdata;
    logic [63:0]         m_axis_tkeep;
    logic [127:0]        m_axis_tuser;
    logic                m_axis_tvalid;
    logic                m_axis_tready;
    logic                m_axis_tlast;
    logic                err_len;

    modport master (
        input  cmd_valid, cmd_mod_id, cmd_res_id, cmd_len, cmd_payload,
        input  m_axis_tready,
        output cmd_ready, m_axis_tdata, m_axis_tkeep, m_axis_tuser,
        output m_axis_tvalid, m_axis_tlast, err_len
    );

    modport slave (
        output cmd_valid, cmd_mod_id, cmd_res_id, cmd_len, cmd_payload,
        output m_axis_tready,
        input  cmd_ready, m_axis_tdata, m_axis_tkeep, m_axis_tuser,
        input  m_axis_tvalid, m_axis_tlast, err_len
    );

endinterface

// File: rtl/rmt_ctrl_beat_mux.sv
// Picks one 64-byte beat of the header+payload image and its
// byte enables / last flag.
module rmt_ctrl_beat_mux
    import rmt_ctrl_pkg::*;
(
    input  logic [HDR_BITS-1:0] hdr,
    input  logic [PAY_BITS-1:0] payload,
    input  logic [7:0]          pkt_len,
    input  logic [1:0]          sel,
    output logic [511:0]        tdata,
    output logic [63:0]         tkeep,
    output logic                tlast
);

    logic [1535:0] pkt;
    logic [8:0]    rem;

    assign pkt   = {128'b0, payload, hdr};
    assign tdata = pkt[{sel, 9'd0} +: 512];

    // Bytes still owed from this beat onward.
    assign rem   = {1'b0, pkt_len} - {1'b0, sel, 6'd0};
    assign tlast = (rem <= 9'd64);
    assign tkeep = (rem >= 9'd64) ? '1
                 : (64'd1 << rem[5:0]) - 64'd1;

endmodule

// File: rtl/rmt_ctrl_pkt_tx.sv
// Formats one table/state write command into a VLAN-tagged
// IPv4/UDP control packet on a 512-bit AXI-Stream master.
module rmt_ctrl_pkt_tx
    import rmt_ctrl_pkg::*;
#(
    parameter int          C_M_AXIS_DATA_WIDTH  = 512,
    parameter int          C_M_AXIS_TUSER_WIDTH = 128,
    parameter int          MAX_PAYLOAD_BYTES    = 128,
    parameter logic [31:0] SRC_IP               = 32'h6f6f6f6f,
    parameter logic [31:0] DST_IP               = 32'hdededede,
    parameter logic [15:0] UDP_SPORT            = 16'h04d2,
    parameter logic [15:0] UDP_DPORT            = 16'hf1f2,
    parameter logic [11:0] VLAN_ID              = 12'h00f
) (
    input  logic clk,
    input  logic aresetn,
    rmt_ctrl_pkt_tx_if.master io
);

    tx_state_e           state;
    logic [7:0]          lat_mod;
    logic [7:0]          lat_res;
    logic [7:0]          lat_len;
    logic [PAY_BITS-1:0] lat_pay;
    logic [15:0]         ip_id;
    logic [1:0]          beat;
    logic                cmd_ready_q;
    logic                tvalid_q;
    logic                tlast_q;
    logic [63:0]         tkeep_q;
    logic [511:0]        tdata_q;
    logic                err_q;

    logic [15:0]         total_len;
    logic [15:0]         udp_len;
    logic [7:0]          pkt_len;
    logic [15:0]         csum;
    logic [143:0]        eth_be;
    logic [159:0]        ip_be;
    logic [63:0]         udp_be;
    logic [15:0]         ctl_be;
    logic [HDR_BITS-1:0] hdr;
    logic [1:0]          sel;
    logic [C_M_AXIS_DATA_WIDTH-1:0] nxt_data;
    logic [63:0]         nxt_keep;
    logic                nxt_last;
    logic                len_bad;

    assign total_len = 16'd30 + {8'h0, lat_len};
    assign udp_len   = 16'd10 + {8'h0, lat_len};
    assign pkt_len   = 8'(PAY_OFF) + lat_len;
    assign csum      = ipv4_csum({8'h45, 8'h00, total_len, ip_id, 16'h0,
                                  8'h40, 8'h11, 16'h0, SRC_IP, DST_IP});

    assign eth_be = {DST_MAC, SRC_MAC, TPID, 4'h0, VLAN_ID, ETYPE_IPV4};
    assign ip_be  = {8'h45, 8'h00, total_len, ip_id, 16'h0,
                     8'h40, 8'h11, csum, SRC_IP, DST_IP};
    assign udp_be = {UDP_SPORT, UDP_DPORT, udp_len, 16'h0};
    assign ctl_be = {lat_mod, lat_res};

    // Fields are written MSB-first, so reverse bytes onto the wire.
    always_comb begin
        hdr = '0;
        for (int i = 0; i < ETH_BYTES; i++)
            hdr[8*i +: 8] = eth_be[8*(ETH_BYTES-1-i) +: 8];
        for (int i = 0; i < 20; i++)
            hdr[8*(IP_OFF+i) +: 8] = ip_be[8*(19-i) +: 8];
        for (int i = 0; i < 8; i++)
            hdr[8*(UDP_OFF+i) +: 8] = udp_be[8*(7-i) +: 8];
        for (int i = 0; i < 2; i++)
            hdr[8*(CTL_OFF+i) +: 8] = ctl_be[8*(1-i) +: 8];
    end

    assign sel     = (state == SEND) ? beat + 2'd1 : 2'd0;
    assign len_bad = (io.cmd_len == 8'd0)
                  || (int'(io.cmd_len) > MAX_PAYLOAD_BYTES);

    rmt_ctrl_beat_mux u_mux (
        .hdr     (hdr),
        .payload (lat_pay),
        .pkt_len (pkt_len),
        .sel     (sel),
        .tdata   (nxt_data),
        .tkeep   (nxt_keep),
        .tlast   (nxt_last)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b1;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tkeep_q     <= '0;
            tdata_q     <= '0;
            err_q       <= 1'b0;
            ip_id       <= 16'h0001;
            beat        <= 2'd0;
            lat_mod     <= '0;
            lat_res     <= '0;
            lat_len     <= '0;
            lat_pay     <= '0;
        end else begin
            err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (io.cmd_valid) begin
                        if (len_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            lat_mod     <= io.cmd_mod_id;
                            lat_res     <= io.cmd_res_id;
                            lat_len     <= io.cmd_len;
                            lat_pay     <= io.cmd_payload;
                            cmd_ready_q <= 1'b0;
                            state       <= CALC;
                        end
                    end
                end
                CALC: begin
                    tdata_q  <= nxt_data;
                    tkeep_q  <= nxt_keep;
                    tlast_q  <= nxt_last;
                    tvalid_q <= 1'b1;
                    beat     <= 2'd0;
                    state    <= SEND;
                end
                SEND: begin
                    if (io.m_axis_tready) begin
                        if (tlast_q) begin
                            tvalid_q    <= 1'b0;
                            tlast_q     <= 1'b0;
                            tkeep_q     <= '0;
                            ip_id       <= ip_id + 16'd1;
                            cmd_ready_q <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            beat    <= beat + 2'd1;
                            tdata_q <= nxt_data;
                            tkeep_q <= nxt_keep;
                            tlast_q <= nxt_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.cmd_ready     = cmd_ready_q;
    assign io.m_axis_tdata  = tdata_q;
    assign io.m_axis_tkeep  = tkeep_q;
    assign io.m_axis_tuser  = {C_M_AXIS_TUSER_WIDTH{1'b0}};
    assign io.m_axis_tvalid = tvalid_q;
    assign io.m_axis_tlast  = tlast_q;
    assign io.err_len       = err_q;

endmodule

// File: tb/tb_rmt_ctrl_pkt_tx.sv
// Directed, table-driven bench for rmt_ctrl_pkt_tx: packet image,
// lengths, checksum, backpressure, illegal lengths, mid-packet reset.
module tb_rmt_ctrl_pkt_tx;

    typedef struct {
        logic [7:0]  len;
        logic [7:0]  mod;
        logic [7:0]  res;
        logic [7:0]  seed;
        logic [15:0] id;
        logic [5:0]  pat;
        logic [15:0] csum;
        int          beats;
        logic [63:0] lkeep;
    } vec_t;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    rmt_ctrl_pkt_tx_if bus();

    rmt_ctrl_pkt_tx dut (
        .clk     (clk),
        .aresetn (aresetn),
        .io      (bus.master)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] exp_b [192];
    logic [7:0] got_b [192];
    vec_t tbl [5];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] pay(input int k, input logic [7:0] seed);
        return 8'(k) + seed;
    endfunction

    // Reference packet image built straight from the header layout.
    task automatic build_exp(input logic [7:0] len, input logic [7:0] mod,
                             input logic [7:0] res, input logic [7:0] seed,
                             input logic [15:0] id);
        logic [15:0] tl, ul, c;
        logic [31:0] s;
        tl = 16'd30 + 16'(len);
        ul = 16'd10 + 16'(len);
        for (int i = 0; i < 192; i++) exp_b[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            exp_b[i]   = 8'(6 + i);
            exp_b[6+i] = 8'(i);
        end
        exp_b[12] = 8'h81; exp_b[13] = 8'h00;
        exp_b[14] = 8'h00; exp_b[15] = 8'h0f;
        exp_b[16] = 8'h08; exp_b[17] = 8'h00;
        exp_b[18] = 8'h45; exp_b[19] = 8'h00;
        exp_b[20] = tl[15:8]; exp_b[21] = tl[7:0];
        exp_b[22] = id[15:8]; exp_b[23] = id[7:0];
        exp_b[26] = 8'h40; exp_b[27] = 8'h11;
        for (int i = 30; i < 34; i++) exp_b[i] = 8'h6f;
        for (int i = 34; i < 38; i++) exp_b[i] = 8'hde;
        exp_b[38] = 8'h04; exp_b[39] = 8'hd2;
        exp_b[40] = 8'hf1; exp_b[41] = 8'hf2;
        exp_b[42] = ul[15:8]; exp_b[43] = ul[7:0];
        exp_b[46] = mod; exp_b[47] = res;
        for (int k = 0; k < int'(len); k++) exp_b[48+k] = pay(k, seed);
        s = '0;
        for (int i = 18; i < 38; i += 2) s = s + {16'h0, exp_b[i], exp_b[i+1]};
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        c = ~s[15:0];
        exp_b[28] = c[15:8]; exp_b[29] = c[7:0];
    endtask

    task automatic drive_cmd(input logic [7:0] len, input logic [7:0] mod,
                             input logic [7:0] res, input logic [7:0] seed);
        bus.cmd_len    = len;
        bus.cmd_mod_id = mod;
        bus.cmd_res_id = res;
        for (int k = 0; k < 128; k++) bus.cmd_payload[8*k +: 8] = pay(k, seed);
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_len     = 8'hee;
        bus.cmd_mod_id  = 8'h99;
        bus.cmd_res_id  = 8'h88;
        bus.cmd_payload = {32{32'hdeadbeef}};
    endtask

    task automatic run_pkt(input string nm, input vec_t v);
        int cyc, nb, first, pi, bad, plen;
        logic done, held;
        logic [511:0] pdata;
        logic [63:0] pkeep;
        cyc = 0; nb = 0; first = -1; pi = 0; done = 1'b0; held = 1'b0;
        pdata = '0; pkeep = '0;
        plen = 48 + int'(v.len);
        for (int i = 0; i < 192; i++) got_b[i] = 8'hxx;
        build_exp(v.len, v.mod, v.res, v.seed, v.id);
        chk({nm, ".cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
        drive_cmd(v.len, v.mod, v.res, v.seed);
        while (!done && cyc < 60) begin
            if (bus.m_axis_tvalid) begin
                bus.m_axis_tready = v.pat[pi % 6];
                pi++;
                if (first < 0) first = cyc;
                if (held) begin
                    chk({nm, ".hold_data"}, 64'(bus.m_axis_tdata == pdata), 64'(1));
                    chk({nm, ".hold_keep"}, bus.m_axis_tkeep, pkeep);
                end
                if (bus.m_axis_tready) begin
                    chk($sformatf("%s.keep%0d", nm, nb), bus.m_axis_tkeep,
                        (nb == v.beats - 1) ? v.lkeep : 64'hffffffffffffffff);
                    chk($sformatf("%s.last%0d", nm, nb), 64'(bus.m_axis_tlast),
                        64'(nb == v.beats - 1));
                    for (int i = 0; i < 64; i++)
                        if (64*nb + i < 192)
                            got_b[64*nb + i] = bus.m_axis_tdata[8*i +: 8];
                    if (bus.m_axis_tlast) done = 1'b1;
                    nb++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    pdata = bus.m_axis_tdata;
                    pkeep = bus.m_axis_tkeep;
                end
            end else begin
                bus.m_axis_tready = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.m_axis_tready = 1'b0;
        chk({nm, ".done"}, 64'(done), 64'(1));
        chk({nm, ".beats"}, 64'(nb), 64'(v.beats));
        chk({nm, ".latency"}, 64'(first), 64'(1));
        chk({nm, ".total_len"}, 64'({got_b[20], got_b[21]}), 64'(16'd30 + 16'(v.len)));
        chk({nm, ".ip_id"}, 64'({got_b[22], got_b[23]}), 64'(v.id));
        chk({nm, ".csum"}, 64'({got_b[28], got_b[29]}), 64'(v.csum));
        chk({nm, ".udp_len"}, 64'({got_b[42], got_b[43]}), 64'(16'd10 + 16'(v.len)));
        bad = 0;
        for (int i = 0; i < plen; i++) if (got_b[i] !== exp_b[i]) bad++;
        chk({nm, ".bytes"}, 64'(bad), 64'(0));
        chk({nm, ".idle_valid"}, 64'(bus.m_axis_tvalid), 64'(0));
    endtask

    task automatic bad_cmd(input string nm, input logic [7:0] len);
        int extra, vcnt;
        extra = 0; vcnt = 0;
        chk({nm, ".cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
        drive_cmd(len, 8'h01, 8'h02, 8'h00);
        chk({nm, ".err_pulse"}, 64'(bus.err_len), 64'(1));
        if (bus.m_axis_tvalid) vcnt++;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.err_len) extra++;
            if (bus.m_axis_tvalid) vcnt++;
        end
        chk({nm, ".err_extra"}, 64'(extra), 64'(0));
        chk({nm, ".no_tvalid"}, 64'(vcnt), 64'(0));
    endtask

    initial begin
        vec_t v;
        int w;
        tbl[0] = '{8'd16,  8'h01, 8'h00, 8'h00, 16'h0001, 6'b111111,
                   16'hde22, 1, 64'hffffffffffffffff};
        tbl[1] = '{8'd17,  8'h02, 8'h03, 8'h10, 16'h0002, 6'b111111,
                   16'hde20, 2, 64'h0000000000000001};
        tbl[2] = '{8'd128, 8'h05, 8'h07, 8'h80, 16'h0003, 6'b101001,
                   16'hddb0, 3, 64'h0000ffffffffffff};
        tbl[3] = '{8'd80,  8'h0a, 8'h0b, 8'h33, 16'h0004, 6'b110101,
                   16'hdddf, 2, 64'hffffffffffffffff};
        tbl[4] = '{8'd1,   8'hff, 8'hfe, 8'h77, 16'h0005, 6'b111111,
                   16'hde2d, 1, 64'h0001ffffffffffff};

        bus.cmd_valid = 1'b0;
        bus.cmd_len = 8'h00;
        bus.cmd_mod_id = 8'h00;
        bus.cmd_res_id = 8'h00;
        bus.cmd_payload = '0;
        bus.m_axis_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.cmd_ready", 64'(bus.cmd_ready), 64'(1));
        chk("rst.tvalid", 64'(bus.m_axis_tvalid), 64'(0));
        chk("rst.tlast", 64'(bus.m_axis_tlast), 64'(0));
        chk("rst.tkeep", bus.m_axis_tkeep, 64'(0));
        chk("rst.tdata", 64'(bus.m_axis_tdata == '0), 64'(1));
        chk("rst.tuser", 64'(bus.m_axis_tuser == '0), 64'(1));
        chk("rst.err_len", 64'(bus.err_len), 64'(0));
        aresetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            run_pkt($sformatf("vec%0d", i), tbl[i]);
            if (tbl[i].len == 8'd128)
                chk("max.byte127", 64'(got_b[175]), 64'(pay(127, tbl[i].seed)));
        end

        bad_cmd("len0", 8'd0);
        bad_cmd("len129", 8'd129);
        v = '{8'd64, 8'h11, 8'h22, 8'h05, 16'h0006, 6'b010101,
              16'hdded, 2, 64'h0000ffffffffffff};
        run_pkt("after_err", v);

        chk("rst2.cmd_ready", 64'(bus.cmd_ready), 64'(1));
        drive_cmd(8'd128, 8'h03, 8'h04, 8'h40);
        bus.m_axis_tready = 1'b1;
        w = 0;
        while (!bus.m_axis_tvalid && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        chk("rst2.beat0_valid", 64'(bus.m_axis_tvalid), 64'(1));
        @(posedge clk); #1;
        chk("rst2.beat1_valid", 64'(bus.m_axis_tvalid), 64'(1));
        chk("rst2.beat1_last", 64'(bus.m_axis_tlast), 64'(0));
        aresetn = 1'b0;
        #1;
        chk("rst2.tvalid", 64'(bus.m_axis_tvalid), 64'(0));
        chk("rst2.tkeep", bus.m_axis_tkeep, 64'(0));
        bus.m_axis_tready = 1'b0;
        @(posedge clk); #1;
        aresetn = 1'b1;
        @(posedge clk); #1;
        run_pkt("post_rst", tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
